// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage.
//
// Holds the program counter, presents it to a combinational-read instruction
// memory on addy, and latches the returned word into the instruction register
// one cycle later. A small FSM (BOOT -> FETCH -> HALT) sequences start-up and
// the sticky halt.
//
// Configuration macro: FETCH_WRAP_HALT_EN
//   undefined (default): PC wraps 1023 -> 0 and fetching continues.
//   defined: the fetch from 1023 is latched, then the unit halts with PC = 1023.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   stall        in   hold PC and IR this cycle (any coincident branch is dropped)
//   branchTaken  in   redirect fetch to branchTarget
//   branchTarget in   [9:0] redirect address
//   halt         in   stop fetching; sticky until reset
//   RAMOuput     in   [31:0] instruction memory read data for addy
//   addy         out  [9:0] current PC
//   instruction  out  [31:0] instruction register
//   pcOfInstr    out  [9:0] address the instruction register was fetched from
//   valid        out  instruction register holds a live instruction
//   halted       out  unit is in HALT
module fetch_unit #(
    parameter logic [9:0] RESET_PC = 10'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branchTaken,
    input  logic [9:0]  branchTarget,
    input  logic        halt,
    input  logic [31:0] RAMOuput,
    output logic [9:0]  addy,
    output logic [31:0] instruction,
    output logic [9:0]  pcOfInstr,
    output logic        valid,
    output logic        halted
);

    typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

    state_t      state, state_nxt;
    logic [9:0]  pc_p0, pc_nxt;
    logic [31:0] ir_p1, ir_nxt;
    logic [9:0]  pc_of_instr_p1, pc_of_instr_nxt;
    logic        vld_p1, vld_nxt;
    // Set after the last fetch from address 1023 when overflow halts the unit;
    // turns into a halt on the following FETCH cycle.
    logic        wrap_pend, wrap_pend_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= BOOT;
            pc_p0          <= RESET_PC;
            ir_p1          <= 32'd0;
            pc_of_instr_p1 <= 10'd0;
            vld_p1         <= 1'b0;
            wrap_pend      <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc_p0          <= pc_nxt;
            ir_p1          <= ir_nxt;
            pc_of_instr_p1 <= pc_of_instr_nxt;
            vld_p1         <= vld_nxt;
            wrap_pend      <= wrap_pend_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc_p0;
        ir_nxt          = ir_p1;
        pc_of_instr_nxt = pc_of_instr_p1;
        vld_nxt         = vld_p1;
        wrap_pend_nxt   = wrap_pend;
        case (state)
            BOOT: begin
                // halt seen during the boot cycle diverts straight into HALT
                state_nxt = halt ? HALT : FETCH;
            end
            FETCH: begin
                if (halt || wrap_pend) begin
                    state_nxt     = HALT;
                    ir_nxt        = 32'd0;
                    vld_nxt       = 1'b0;
                    wrap_pend_nxt = 1'b0;
                end else if (stall) begin
                    // hold everything; a branch requested now is dropped
                end else if (branchTaken) begin
                    // squash the wrong-path word currently being read
                    pc_nxt  = branchTarget;
                    ir_nxt  = 32'd0;
                    vld_nxt = 1'b0;
                end else begin
                    ir_nxt          = RAMOuput;
                    pc_of_instr_nxt = pc_p0;
                    vld_nxt         = 1'b1;
                    pc_nxt          = pc_p0 + 10'd1;
`ifdef FETCH_WRAP_HALT_EN
                    if (pc_p0 == 10'd1023) begin
                        pc_nxt        = pc_p0;
                        wrap_pend_nxt = 1'b1;
                    end
`endif
                end
            end
            HALT: begin
                // sticky: only reset leaves HALT
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    assign addy        = pc_p0;
    assign instruction = ir_p1;
    assign pcOfInstr   = pc_of_instr_p1;
    assign valid       = vld_p1;
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branchTaken = 1'b0;
    logic [9:0]  branchTarget = 10'd0;
    logic        halt = 1'b0;
    logic [31:0] RAMOuput;
    logic [9:0]  addy;
    logic [31:0] instruction;
    logic [9:0]  pcOfInstr;
    logic        valid;
    logic        halted;

    int nchecks = 0;
    int nerr = 0;

    fetch_unit #(.RESET_PC(10'd0)) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .branchTaken (branchTaken),
        .branchTarget(branchTarget),
        .halt        (halt),
        .RAMOuput    (RAMOuput),
        .addy        (addy),
        .instruction (instruction),
        .pcOfInstr   (pcOfInstr),
        .valid       (valid),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    // Instruction memory contents: two fixed words, elsewhere a tagged address.
    function automatic logic [31:0] mem(input logic [9:0] a);
        if (a == 10'd0) return 32'h5440_0000;
        if (a == 10'd1) return 32'h5800_0000;
        return 32'hA000_0000 | {22'd0, a};
    endfunction

    assign RAMOuput = mem(addy);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        // reset held across an edge
        step();
        check("rst_addy", 32'(addy), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_pcoi", 32'(pcOfInstr), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);

        // boot cycle then two fetches
        release_reset();
        step();
        check("boot_valid", 32'(valid), 32'd0);
        check("boot_addy", 32'(addy), 32'd0);
        step();
        check("f0_instr", instruction, 32'h5440_0000);
        check("f0_pcoi", 32'(pcOfInstr), 32'd0);
        check("f0_valid", 32'(valid), 32'd1);
        step();
        check("f1_instr", instruction, 32'h5800_0000);
        check("f1_pcoi", 32'(pcOfInstr), 32'd1);
        check("f1_addy", 32'(addy), 32'd2);

        // run up to PC=5, then stall three cycles
        step(); step(); step();
        check("pc5_addy", 32'(addy), 32'd5);
        check("pc5_instr", instruction, 32'hA000_0004);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addy", 32'(addy), 32'd5);
            check("stall_instr", instruction, 32'hA000_0004);
        end
        stall = 1'b0;
        step();
        check("resume_addy", 32'(addy), 32'd6);
        check("resume_pcoi", 32'(pcOfInstr), 32'd5);
        step();
        check("pc7_addy", 32'(addy), 32'd7);

        // branch coincident with stall is dropped
        stall = 1'b1; branchTaken = 1'b1; branchTarget = 10'd300;
        step();
        check("brstall_addy", 32'(addy), 32'd7);
        stall = 1'b0;
        step();
        check("br_addy", 32'(addy), 32'd300);
        check("br_valid", 32'(valid), 32'd0);
        check("br_instr", instruction, 32'd0);
        branchTaken = 1'b0;
        step();
        check("br_pcoi", 32'(pcOfInstr), 32'd300);
        check("br_valid2", 32'(valid), 32'd1);
        check("br_instr2", instruction, 32'hA000_012C);

        // halt pulse at PC=12, held against branches
        branchTaken = 1'b1; branchTarget = 10'd12;
        step();
        check("pc12_addy", 32'(addy), 32'd12);
        branchTaken = 1'b0; halt = 1'b1;
        step();
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_valid", 32'(valid), 32'd0);
        check("halt_instr", instruction, 32'd0);
        halt = 1'b0; branchTaken = 1'b1; branchTarget = 10'd55;
        for (int i = 0; i < 20; i++) begin
            step();
            check("halt_hold_addy", 32'(addy), 32'd12);
            check("halt_hold_h", 32'(halted), 32'd1);
        end
        branchTaken = 1'b0;

        // asynchronous reset out of HALT
        #2 reset = 1'b1;
        #1;
        check("hrst_addy", 32'(addy), 32'd0);
        check("hrst_halted", 32'(halted), 32'd0);
        release_reset();
        step();
        check("hrst_boot_valid", 32'(valid), 32'd0);
        check("hrst_boot_h", 32'(halted), 32'd0);

        // halt during the boot cycle
        @(negedge clock) reset = 1'b1;
        halt = 1'b1;
        release_reset();
        step();
        check("boothalt_h", 32'(halted), 32'd1);
        check("boothalt_addy", 32'(addy), 32'd0);
        check("boothalt_valid", 32'(valid), 32'd0);
        halt = 1'b0;

        // PC overflow
        @(negedge clock) reset = 1'b1;
        release_reset();
        step();
        branchTaken = 1'b1; branchTarget = 10'd1023;
        step();
        check("wr_addy", 32'(addy), 32'd1023);
        branchTaken = 1'b0;
        step();
        check("wr_pcoi", 32'(pcOfInstr), 32'd1023);
        check("wr_valid", 32'(valid), 32'd1);
        check("wr_instr", instruction, 32'hA000_03FF);
`ifdef FETCH_WRAP_HALT_EN
        check("wr_addy1", 32'(addy), 32'd1023);
        check("wr_h1", 32'(halted), 32'd0);
        step();
        check("wr_h2", 32'(halted), 32'd1);
        check("wr_addy2", 32'(addy), 32'd1023);
        check("wr_valid2", 32'(valid), 32'd0);
`else
        check("wr_addy1", 32'(addy), 32'd0);
        step();
        check("wr_addy2", 32'(addy), 32'd1);
        check("wr_pcoi2", 32'(pcOfInstr), 32'd0);
        check("wr_h2", 32'(halted), 32'd0);
`endif

        // asynchronous reset between edges during a stall
        @(negedge clock) reset = 1'b1;
        release_reset();
        step(); step(); step();
        check("ast_pre_addy", 32'(addy), 32'd2);
        stall = 1'b1;
        step();
        #3 reset = 1'b1;
        #1;
        check("ast_instr", instruction, 32'd0);
        check("ast_valid", 32'(valid), 32'd0);
        check("ast_addy", 32'(addy), 32'd0);
        check("ast_pcoi", 32'(pcOfInstr), 32'd0);
        check("ast_halted", 32'(halted), 32'd0);
        stall = 1'b0;

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 10'd0: address fetched first after reset.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port stall, input, 1: hold PC and IR this cycle.
REQ-005 SHALL have port branchTaken, input, 1: redirect fetch to branchTarget.
REQ-006 SHALL have port branchTarget, input, 10: redirect address.
REQ-007 SHALL have port halt, input, 1: stop fetching; sticky until reset.
REQ-008 SHALL have port RAMOuput, input, 32: combinational read data from the instruction memory, addressed by addy.
REQ-009 SHALL have port addy, output, 10: current PC, driven to the instruction memory.
REQ-010 SHALL have port instruction, output, 32: latched instruction register (IR) to decode.
REQ-011 SHALL have port pcOfInstr, output, 10: address IR was fetched from.
REQ-012 SHALL have port valid, output, 1: IR holds a live instruction.
REQ-013 SHALL have port halted, output, 1: high while in state HALT.

Function
REQ-014 SHALL implement states BOOT, FETCH, HALT; addy SHALL equal the PC register at all times.
REQ-015 BOOT SHALL last exactly one cycle after reset release, keep PC=RESET_PC and valid=0, then enter FETCH.
REQ-016 In FETCH, action SHALL be chosen by priority halt > stall > branchTaken > increment.
REQ-017 Increment: IR<=RAMOuput, pcOfInstr<=PC, valid<=1, PC<=PC+1; latency from addy to instruction is one cycle.
REQ-018 Stall: PC, IR, pcOfInstr, valid SHALL all hold; a coincident branchTaken SHALL be ignored and must be re-asserted by the requester.
REQ-019 Branch: PC<=branchTarget, IR<=32'd0, valid<=0 (squash of the in-flight wrong-path fetch); the target instruction appears one cycle later.
REQ-020 Halt: enter HALT; IR<=32'd0, valid<=0, PC holds; halted=1. HALT SHALL persist regardless of stall/branch/halt until reset.
REQ-021 PC arithmetic SHALL be 10-bit modulo; 1023+1 wraps to 0 unless REQ-027 applies.
REQ-022 halt asserted during BOOT SHALL be registered, entering HALT at the BOOT->FETCH transition instead of FETCH.

Reset
REQ-023 Reset assertion SHALL immediately, without a clock, force state=BOOT, PC=RESET_PC, IR=32'd0, pcOfInstr=0, valid=0, halted=0.
REQ-024 Reset mid-stall, mid-branch or in HALT SHALL behave identically to REQ-023; no pending branch or halt survives reset.
REQ-025 Outputs SHALL remain at reset values while reset is high, and for the single BOOT cycle after release.

Configuration
REQ-026 Macro FETCH_WRAP_HALT_EN SHALL select PC-overflow handling.
REQ-027 With FETCH_WRAP_HALT_EN defined: an increment from PC=1023 SHALL latch that instruction (valid=1) and then enter HALT with PC held at 1023.
REQ-028 Without it: PC wraps 1023->0 and fetching continues (REQ-021).

Verification
REQ-029 Reset, release, RAMOuput=mem[addy] with mem[0]=32'h5440_0000, mem[1]=32'h5800_0000 -> cycle 1 valid=0; cycle 2 instruction=32'h5440_0000, pcOfInstr=0; cycle 3 instruction=32'h5800_0000, pcOfInstr=1.
REQ-030 At PC=5, stall for 3 cycles -> addy=5 and IR unchanged for 3 cycles; fetch resumes with PC=6 on the next cycle.
REQ-031 At PC=7, branchTaken=1, branchTarget=10'd300 -> next cycle addy=300, valid=0; following cycle pcOfInstr=300, valid=1. Same with stall=1 -> branch ignored, addy=7.
REQ-032 halt pulsed one cycle at PC=12 -> halted=1, valid=0, addy=12 held for 20 cycles despite branchTaken; reset -> BOOT, addy=RESET_PC.
REQ-033 Branch to 1023, run two cycles -> without macro addy=0 then 1; with FETCH_WRAP_HALT_EN pcOfInstr=1023 valid=1, then halted=1, addy=1023.
REQ-034 Assert reset asynchronously between clock edges during a stall -> outputs reach reset values before the next rising edge.
